seq_playback: RTL

- Upstream stage of the 4-bit sequence decoder ROM.
- Generates the step address the decoder consumes and replays steps 0..round on the 4 LEDs, one step at a time.
- Timing is driven by an external slow enable pulse `tick`.
- Used by the game controller to show the pattern before the player's input phase. Asserts `done` when playback finishes.

---
 rtl/seq_playback_pkg.sv | 21 ++
 rtl/seq_playback_tick_timer.sv | 27 ++
 rtl/seq_playback.sv | 98 +++++++++
 3 files changed

// File: rtl/seq_playback_pkg.sv
// rtl/seq_playback_pkg.sv - shared state encoding and default widths for the pattern playback path
package seq_playback_pkg;

  localparam int ADDR_W_DEF = 4;
  localparam int LED_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SHOW = 2'b01,
    GAP  = 2'b10,
    DONE = 2'b11
  } state_t;

  // Counter width for the longer of the two phases; never narrower than one bit.
  function automatic int cnt_width(input int on_ticks, input int off_ticks);
    int longest;
    longest = (on_ticks > off_ticks) ? on_ticks : off_ticks;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/seq_playback_tick_timer.sv
// rtl/seq_playback_tick_timer.sv - tick-qualified phase counter with terminal compare
module seq_playback_tick_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             tick,
  input  logic [CNT_W-1:0] last,
  output logic             expire
);

  logic [CNT_W-1:0] cnt;

  assign expire = tick && (cnt == last);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (expire) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_playback.sv
// rtl/seq_playback.sv - steps the decoder address through 0..round and shows each pattern on the LEDs
module seq_playback
  import seq_playback_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int LED_W     = LED_W_DEF,
  parameter int TICKS_ON  = 4,
  parameter int TICKS_OFF = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] round,
  input  logic              tick,
  output logic [ADDR_W-1:0] address,
  input  logic [LED_W-1:0]  seq_in,
  output logic [LED_W-1:0]  led_out,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = cnt_width(TICKS_ON, TICKS_OFF);
  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(TICKS_ON - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(TICKS_OFF - 1);

  state_t            state;
  state_t            state_d;
  logic [ADDR_W-1:0] last_reg;
  logic [ADDR_W-1:0] last_d;
  logic [ADDR_W-1:0] address_d;
  logic              expire;
  logic              timer_clear;
  logic [CNT_W-1:0]  timer_last;

  // The counter is parked at zero outside SHOW/GAP so every step starts a fresh phase.
  assign timer_clear = (state == IDLE) || (state == DONE);
  assign timer_last  = (state == GAP) ? OFF_LAST : ON_LAST;

  seq_playback_tick_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .tick   (tick),
    .last   (timer_last),
    .expire (expire)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      address  <= '0;
      last_reg <= '0;
    end else begin
      state    <= state_d;
      address  <= address_d;
      last_reg <= last_d;
    end
  end

  always_comb begin
    state_d   = state;
    address_d = address;
    last_d    = last_reg;
    case (state)
      IDLE: begin
        if (start) begin
          last_d    = round;
          address_d = '0;
          state_d   = SHOW;
        end
      end
      SHOW: begin
        if (expire) state_d = GAP;
      end
      GAP: begin
        // Stop on the latched last step so the address never wraps past it.
        if (expire) begin
          if (address == last_reg) begin
            state_d = DONE;
          end else begin
            address_d = address + ADDR_W'(1);
            state_d   = SHOW;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy    = (state == SHOW) || (state == GAP);
  assign done    = (state == DONE);
  assign led_out = (state == SHOW) ? seq_in : '0;

endmodule
